// File: rtl/punc_control.sv
// Multi-cycle LC-3 style control unit: FETCH/DECODE/EXEC(/EXEC2) sequencing
// with every control output registered, computed from the state being entered.
module punc_control #(
  parameter logic [3:0] HALT_OP = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        n,
  input  logic        z,
  input  logic        p,
  output logic        ir_ld,
  output logic        pc_inc,
  output logic        pc_ld,
  output logic        pc_data_sel,
  output logic        pc_add_sel,
  output logic [1:0]  addr_mem_sel,
  output logic        w_en_mem,
  output logic [1:0]  w_rf_sel,
  output logic [2:0]  r_addr_0_rf,
  output logic [2:0]  r_addr_1_rf,
  output logic [2:0]  w_addr_rf,
  output logic        w_en_rf,
  output logic        a_sel,
  output logic        b_sel,
  output logic [1:0]  alu_op,
  output logic        nzp_sel,
  output logic        cc_ld,
  output logic        store_ld,
  output logic        halted
);

  localparam logic [3:0] OP_BR  = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_LD  = 4'h2;
  localparam logic [3:0] OP_ST  = 4'h3;
  localparam logic [3:0] OP_JSR = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_LDR = 4'h6;
  localparam logic [3:0] OP_STR = 4'h7;
  localparam logic [3:0] OP_NOT = 4'h9;
  localparam logic [3:0] OP_LDI = 4'hA;
  localparam logic [3:0] OP_STI = 4'hB;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_LEA = 4'hE;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_EXEC2, S_HALT} state_t;

  typedef struct packed {
    logic       ir_ld;
    logic       pc_inc;
    logic       pc_ld;
    logic       pc_data_sel;
    logic       pc_add_sel;
    logic [1:0] addr_mem_sel;
    logic       w_en_mem;
    logic [1:0] w_rf_sel;
    logic [2:0] r_addr_0;
    logic [2:0] r_addr_1;
    logic [2:0] w_addr;
    logic       w_en_rf;
    logic       a_sel;
    logic       b_sel;
    logic [1:0] alu_op;
    logic       nzp_sel;
    logic       cc_ld;
    logic       store_ld;
    logic       halted;
  } ctl_t;

  state_t     r_state;
  state_t     w_nxt_state;
  state_t     w_tgt;
  ctl_t       r_ctl;
  ctl_t       w_nxt_ctl;
  logic [3:0] w_op;
  logic       w_br_take;
  logic       w_unused_ir;

  assign w_op        = ir[15:12];
  assign w_br_take   = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);
  assign w_unused_ir = ^ir[4:3];

  // Sequencing; reset overrides the target so outputs land on FETCH values.
  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      S_FETCH:  w_nxt_state = S_DECODE;
      S_DECODE: w_nxt_state = (w_op == HALT_OP) ? S_HALT : S_EXEC;
      S_EXEC:   w_nxt_state = (w_op == OP_LDI || w_op == OP_STI) ? S_EXEC2 : S_FETCH;
      S_EXEC2:  w_nxt_state = S_FETCH;
      S_HALT:   w_nxt_state = S_HALT;
      default:  w_nxt_state = S_FETCH;
    endcase
    w_tgt = rst ? S_FETCH : w_nxt_state;
  end

  // Control word for the state about to be entered; IR is stable from DECODE on.
  always_comb begin
    w_nxt_ctl = '0;
    case (w_tgt)
      S_FETCH: begin
        w_nxt_ctl.ir_ld  = 1'b1;
        w_nxt_ctl.pc_inc = 1'b1;
      end
      S_EXEC: begin
        case (w_op)
          OP_ADD, OP_AND, OP_NOT: begin
            w_nxt_ctl.r_addr_0 = ir[8:6];
            w_nxt_ctl.a_sel    = 1'b1;
            w_nxt_ctl.w_rf_sel = 2'b10;
            w_nxt_ctl.w_addr   = ir[11:9];
            w_nxt_ctl.w_en_rf  = 1'b1;
            w_nxt_ctl.cc_ld    = 1'b1;
            if (w_op == OP_NOT) begin
              w_nxt_ctl.alu_op = 2'b10;
            end else begin
              w_nxt_ctl.r_addr_1 = ir[2:0];
              w_nxt_ctl.b_sel    = ir[5];
              w_nxt_ctl.alu_op   = (w_op == OP_AND) ? 2'b01 : 2'b00;
            end
          end
          OP_BR: begin
            if (w_br_take) begin
              w_nxt_ctl.pc_ld      = 1'b1;
              w_nxt_ctl.pc_add_sel = 1'b1;
            end
          end
          OP_JMP: begin
            w_nxt_ctl.r_addr_0    = ir[8:6];
            w_nxt_ctl.pc_data_sel = 1'b1;
            w_nxt_ctl.pc_ld       = 1'b1;
          end
          OP_JSR: begin
            w_nxt_ctl.w_addr   = 3'd7;
            w_nxt_ctl.w_rf_sel = 2'b00;
            w_nxt_ctl.w_en_rf  = 1'b1;
            w_nxt_ctl.pc_ld    = 1'b1;
            if (!ir[11]) begin
              w_nxt_ctl.pc_data_sel = 1'b1;
              w_nxt_ctl.r_addr_0    = ir[8:6];
            end
          end
          OP_LD, OP_LDR, OP_LEA: begin
            w_nxt_ctl.a_sel   = (w_op == OP_LDR);
            w_nxt_ctl.b_sel   = 1'b1;
            w_nxt_ctl.w_addr  = ir[11:9];
            w_nxt_ctl.w_en_rf = 1'b1;
            w_nxt_ctl.cc_ld   = 1'b1;
            if (w_op == OP_LDR) w_nxt_ctl.r_addr_0 = ir[8:6];
            if (w_op == OP_LEA) begin
              w_nxt_ctl.w_rf_sel = 2'b10;
            end else begin
              w_nxt_ctl.addr_mem_sel = 2'b01;
              w_nxt_ctl.w_rf_sel     = 2'b01;
              w_nxt_ctl.nzp_sel      = 1'b1;
            end
          end
          OP_ST, OP_STR: begin
            w_nxt_ctl.a_sel        = (w_op == OP_STR);
            w_nxt_ctl.b_sel        = 1'b1;
            w_nxt_ctl.addr_mem_sel = 2'b01;
            w_nxt_ctl.r_addr_1     = ir[11:9];
            w_nxt_ctl.w_en_mem     = 1'b1;
            if (w_op == OP_STR) w_nxt_ctl.r_addr_0 = ir[8:6];
          end
          OP_LDI, OP_STI: begin
            w_nxt_ctl.b_sel        = 1'b1;
            w_nxt_ctl.addr_mem_sel = 2'b01;
            w_nxt_ctl.store_ld     = 1'b1;
          end
          default: ;
        endcase
      end
      S_EXEC2: begin
        w_nxt_ctl.addr_mem_sel = 2'b10;
        if (w_op == OP_LDI) begin
          w_nxt_ctl.w_addr   = ir[11:9];
          w_nxt_ctl.w_rf_sel = 2'b01;
          w_nxt_ctl.w_en_rf  = 1'b1;
          w_nxt_ctl.cc_ld    = 1'b1;
          w_nxt_ctl.nzp_sel  = 1'b1;
        end else begin
          w_nxt_ctl.w_en_mem = 1'b1;
          w_nxt_ctl.r_addr_1 = ir[11:9];
        end
      end
      S_HALT:  w_nxt_ctl.halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_nxt_state;
    r_ctl <= w_nxt_ctl;
  end

  assign ir_ld        = r_ctl.ir_ld;
  assign pc_inc       = r_ctl.pc_inc;
  assign pc_ld        = r_ctl.pc_ld;
  assign pc_data_sel  = r_ctl.pc_data_sel;
  assign pc_add_sel   = r_ctl.pc_add_sel;
  assign addr_mem_sel = r_ctl.addr_mem_sel;
  assign w_en_mem     = r_ctl.w_en_mem;
  assign w_rf_sel     = r_ctl.w_rf_sel;
  assign r_addr_0_rf  = r_ctl.r_addr_0;
  assign r_addr_1_rf  = r_ctl.r_addr_1;
  assign w_addr_rf    = r_ctl.w_addr;
  assign w_en_rf      = r_ctl.w_en_rf;
  assign a_sel        = r_ctl.a_sel;
  assign b_sel        = r_ctl.b_sel;
  assign alu_op       = r_ctl.alu_op;
  assign nzp_sel      = r_ctl.nzp_sel;
  assign cc_ld        = r_ctl.cc_ld;
  assign store_ld     = r_ctl.store_ld;
  assign halted       = r_ctl.halted;

endmodule

// File: tb/tb_punc_control.sv
// Scoreboard bench for punc_control: per-cycle expected control words are
// queued per instruction and compared against the outputs each cycle.
module tb_punc_control;

  typedef struct packed {
    logic       ir_ld;
    logic       pc_inc;
    logic       pc_ld;
    logic       pc_data_sel;
    logic       pc_add_sel;
    logic [1:0] addr_mem_sel;
    logic       w_en_mem;
    logic [1:0] w_rf_sel;
    logic [2:0] r_addr_0;
    logic [2:0] r_addr_1;
    logic [2:0] w_addr;
    logic       w_en_rf;
    logic       a_sel;
    logic       b_sel;
    logic [1:0] alu_op;
    logic       nzp_sel;
    logic       cc_ld;
    logic       store_ld;
    logic       halted;
  } ctl_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ir;
  logic        n, z, p;
  logic        ir_ld, pc_inc, pc_ld, pc_data_sel, pc_add_sel, w_en_mem, w_en_rf;
  logic        a_sel, b_sel, nzp_sel, cc_ld, store_ld, halted;
  logic [1:0]  addr_mem_sel, w_rf_sel, alu_op;
  logic [2:0]  r_addr_0_rf, r_addr_1_rf, w_addr_rf;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  ctl_t        exp_q[$];
  string       tag_q[$];
  ctl_t        obs;
  ctl_t        c_fetch, c_zero, c_halt, e, e2;

  punc_control #(.HALT_OP(4'hF)) dut (
    .clk(clk), .rst(rst), .ir(ir), .n(n), .z(z), .p(p),
    .ir_ld(ir_ld), .pc_inc(pc_inc), .pc_ld(pc_ld), .pc_data_sel(pc_data_sel),
    .pc_add_sel(pc_add_sel), .addr_mem_sel(addr_mem_sel), .w_en_mem(w_en_mem),
    .w_rf_sel(w_rf_sel), .r_addr_0_rf(r_addr_0_rf), .r_addr_1_rf(r_addr_1_rf),
    .w_addr_rf(w_addr_rf), .w_en_rf(w_en_rf), .a_sel(a_sel), .b_sel(b_sel),
    .alu_op(alu_op), .nzp_sel(nzp_sel), .cc_ld(cc_ld), .store_ld(store_ld),
    .halted(halted)
  );

  always #5 clk = ~clk;

  assign obs = {ir_ld, pc_inc, pc_ld, pc_data_sel, pc_add_sel, addr_mem_sel, w_en_mem,
                w_rf_sel, r_addr_0_rf, r_addr_1_rf, w_addr_rf, w_en_rf, a_sel, b_sel,
                alu_op, nzp_sel, cc_ld, store_ld, halted};

  task automatic check(input string tag, input ctl_t got, input ctl_t want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic push(input string tag, input ctl_t want);
    exp_q.push_back(want);
    tag_q.push_back(tag);
  endtask

  // One comparison per cycle, sampled 1 time unit after the rising edge.
  task automatic drain();
    ctl_t  w;
    string t;
    while (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, obs, w);
      @(posedge clk); #1;
    end
  endtask

  // Called in a FETCH cycle; leaves the bench in the next FETCH cycle.
  task automatic instr(input string tag, input logic [15:0] i, input logic [2:0] nzp,
                       input ctl_t ex, input bit two, input ctl_t ex2);
    ir = i;
    {n, z, p} = nzp;
    push({tag, "_fetch"}, c_fetch);
    push({tag, "_decode"}, c_zero);
    push({tag, "_exec"}, ex);
    if (two) push({tag, "_exec2"}, ex2);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    c_fetch = '0; c_fetch.ir_ld = 1'b1; c_fetch.pc_inc = 1'b1;
    c_zero  = '0;
    c_halt  = '0; c_halt.halted = 1'b1;
    rst = 1'b1; ir = 16'h0000; {n, z, p} = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", obs, c_fetch);
    rst = 1'b0;

    e = '0; e.r_addr_0 = 3'd1; e.r_addr_1 = 3'd1; e.b_sel = 1; e.a_sel = 1;
    e.w_rf_sel = 2'b10; e.w_addr = 3'd1; e.w_en_rf = 1; e.cc_ld = 1;
    instr("add_imm", 16'h1261, 3'b000, e, 0, c_zero);

    e = '0; e.r_addr_0 = 3'd2; e.r_addr_1 = 3'd3; e.a_sel = 1; e.alu_op = 2'b01;
    e.w_rf_sel = 2'b10; e.w_addr = 3'd5; e.w_en_rf = 1; e.cc_ld = 1;
    instr("and_reg", 16'h5A83, 3'b000, e, 0, c_zero);

    e = '0; e.r_addr_0 = 3'd1; e.a_sel = 1; e.alu_op = 2'b10;
    e.w_rf_sel = 2'b10; e.w_addr = 3'd3; e.w_en_rf = 1; e.cc_ld = 1;
    instr("not", 16'h967F, 3'b000, e, 0, c_zero);

    e = '0; e.pc_ld = 1; e.pc_add_sel = 1;
    instr("brz_taken", 16'h0402, 3'b010, e, 0, c_zero);
    instr("brz_not_taken", 16'h0402, 3'b100, c_zero, 0, c_zero);
    instr("brnzp_p", 16'h0E02, 3'b001, e, 0, c_zero);

    e = '0; e.r_addr_0 = 3'd7; e.pc_data_sel = 1; e.pc_ld = 1;
    instr("jmp", 16'hC1C0, 3'b000, e, 0, c_zero);

    e = '0; e.w_addr = 3'd7; e.w_en_rf = 1; e.pc_ld = 1;
    instr("jsr", 16'h4802, 3'b000, e, 0, c_zero);
    e.pc_data_sel = 1; e.r_addr_0 = 3'd2;
    instr("jsrr", 16'h4080, 3'b000, e, 0, c_zero);

    e = '0; e.b_sel = 1; e.addr_mem_sel = 2'b01; e.w_rf_sel = 2'b01; e.nzp_sel = 1;
    e.w_addr = 3'd5; e.w_en_rf = 1; e.cc_ld = 1;
    instr("ld", 16'h2A10, 3'b000, e, 0, c_zero);
    e.a_sel = 1; e.r_addr_0 = 3'd2; e.w_addr = 3'd6;
    instr("ldr", 16'h6C85, 3'b000, e, 0, c_zero);

    e = '0; e.b_sel = 1; e.w_rf_sel = 2'b10; e.w_addr = 3'd3; e.w_en_rf = 1; e.cc_ld = 1;
    instr("lea", 16'hE605, 3'b000, e, 0, c_zero);

    e = '0; e.b_sel = 1; e.addr_mem_sel = 2'b01; e.r_addr_1 = 3'd5; e.w_en_mem = 1;
    instr("st", 16'h3A04, 3'b000, e, 0, c_zero);
    e.a_sel = 1; e.r_addr_0 = 3'd2; e.r_addr_1 = 3'd1;
    instr("str", 16'h7283, 3'b000, e, 0, c_zero);

    e = '0; e.b_sel = 1; e.addr_mem_sel = 2'b01; e.store_ld = 1;
    e2 = '0; e2.addr_mem_sel = 2'b10; e2.w_addr = 3'd2; e2.w_rf_sel = 2'b01;
    e2.w_en_rf = 1; e2.cc_ld = 1; e2.nzp_sel = 1;
    instr("ldi", 16'hA405, 3'b000, e, 1, e2);
    e2 = '0; e2.addr_mem_sel = 2'b10; e2.w_en_mem = 1; e2.r_addr_1 = 3'd3;
    instr("sti", 16'hB605, 3'b000, e, 1, e2);

    instr("unused_8", 16'h8123, 3'b111, c_zero, 0, c_zero);
    instr("unused_d", 16'hD123, 3'b111, c_zero, 0, c_zero);

    // STI interrupted by reset before its second cycle.
    ir = 16'hB605; {n, z, p} = 3'b000;
    push("sti_rst_fetch", c_fetch);
    push("sti_rst_decode", c_zero);
    drain();
    check("sti_rst_exec", obs, e);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    e = '0; e.r_addr_0 = 3'd1; e.r_addr_1 = 3'd1; e.b_sel = 1; e.a_sel = 1;
    e.w_rf_sel = 2'b10; e.w_addr = 3'd1; e.w_en_rf = 1; e.cc_ld = 1;
    instr("after_sti_rst", 16'h1261, 3'b000, e, 0, c_zero);

    // HALT holds until reset.
    ir = 16'hF025;
    push("halt_fetch", c_fetch);
    push("halt_decode", c_zero);
    for (int k = 0; k < 12; k++) push($sformatf("halt_hold%0d", k), c_halt);
    drain();
    rst = 1'b1;
    ir = 16'h1261;
    @(posedge clk); #1;
    rst = 1'b0;
    instr("after_halt_rst", 16'h1261, 3'b000, e, 0, c_zero);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
